// File: rtl/traffic_pkg.sv
// traffic_pkg: encodings shared by the traffic light controller slice.
//   LIGHT_GREEN / LIGHT_YELLOW / LIGHT_RED : one-hot lr_light encodings
//   deb_state_t                            : sensor debounce FSM states
//   cnt_width()                            : counter width able to hold n-1 (min 1)
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b001;

  typedef enum logic [1:0] {
    DEB_IDLE     = 2'b00,
    DEB_RISE_CHK = 2'b01,
    DEB_PRESENT  = 2'b10,
    DEB_FALL_CHK = 2'b11
  } deb_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchroniser plus 4-state debounce FSM for the
// local-road vehicle loop sensor.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   sensor_raw : asynchronous loop sensor, high while a car is over the loop
//   car_arrive : one-cycle pulse, high on the cycle RISE_CHK -> PRESENT is taken
//   state      : current debounce state
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_raw,
  output logic       car_arrive,
  output deb_state_t state
);

  localparam int unsigned     DW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]   DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0]   DEB_ONE  = DW'(1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_cnt_next;
  deb_state_t    state_next;

  // car_arrive is combinational so the queue counts on the same edge the
  // FSM enters PRESENT.
  always_comb begin
    state_next   = state;
    deb_cnt_next = deb_cnt;
    car_arrive   = 1'b0;
    case (state)
      DEB_IDLE: begin
        if (sync2) begin
          state_next   = DEB_RISE_CHK;
          deb_cnt_next = DEB_ONE;
        end
      end
      DEB_RISE_CHK: begin
        if (!sync2) begin
          state_next = DEB_IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_next = DEB_PRESENT;
          car_arrive = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt + DEB_ONE;
        end
      end
      DEB_PRESENT: begin
        if (!sync2) begin
          state_next   = DEB_FALL_CHK;
          deb_cnt_next = DEB_ONE;
        end
      end
      DEB_FALL_CHK: begin
        if (sync2) begin
          state_next = DEB_PRESENT;
        end else if (deb_cnt == DEB_LAST) begin
          state_next = DEB_IDLE;
        end else begin
          deb_cnt_next = deb_cnt + DEB_ONE;
        end
      end
      default: begin
        state_next   = DEB_IDLE;
        deb_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      state   <= DEB_IDLE;
      deb_cnt <= '0;
    end else begin
      sync1   <= sensor_raw;
      sync2   <= sync1;
      state   <= state_next;
      deb_cnt <= deb_cnt_next;
    end
  end

endmodule

// File: rtl/lr_car_detector.sv
// lr_car_detector: conditions the local-road loop sensor and produces the
// lr_has_car request. Debounced arrivals fill a saturating car queue that
// drains one car per PASS_CYCLES consecutive local-road green cycles.
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   sensor_raw   : asynchronous loop sensor
//   lr_light     : local-road light (100 green, 010 yellow, 001 red)
//   lr_has_car   : registered request, high while cars are queued (or faulted)
//   car_count    : queued cars, saturating at MAX_CARS
//   sensor_fault : stuck-sensor flag
// Build option: define LR_CAR_STUCK_DETECT_EN to enable stuck-sensor
// detection; otherwise sensor_fault is tied low.
module lr_car_detector
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_CARS        = 7,
  parameter int unsigned PASS_CYCLES     = 10,
  parameter int unsigned STUCK_CYCLES    = 200
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sensor_raw,
  input  logic [2:0]                      lr_light,
  output logic                            lr_has_car,
  output logic [$clog2(MAX_CARS+1)-1:0]   car_count,
  output logic                            sensor_fault
);

  localparam int unsigned   CW        = $clog2(MAX_CARS + 1);
  localparam logic [CW-1:0] CAR_MAX   = CW'(MAX_CARS);
  localparam logic [CW-1:0] CAR_ONE   = CW'(1);
  localparam int unsigned   PW        = cnt_width(PASS_CYCLES);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASS_CYCLES - 1);
  localparam logic [PW-1:0] PASS_ONE  = PW'(1);

  logic          car_arrive;
  deb_state_t    deb_state;
  logic          green;
  logic          drain_tick;
  logic [PW-1:0] pass_cnt;
  logic [CW-1:0] count_next;
  logic          fault_next;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sensor_debounce (
    .clk       (clk),
    .rst       (rst),
    .sensor_raw(sensor_raw),
    .car_arrive(car_arrive),
    .state     (deb_state)
  );

  assign green      = (lr_light == LIGHT_GREEN);
  assign drain_tick = green && (pass_cnt == PASS_LAST);

  // An arrival and a drain on the same edge cancel, even at the
  // saturation and empty limits.
  always_comb begin
    count_next = car_count;
    if (car_arrive && !drain_tick) begin
      if (car_count != CAR_MAX) begin
        count_next = car_count + CAR_ONE;
      end
    end else if (drain_tick && !car_arrive) begin
      if (car_count != '0) begin
        count_next = car_count - CAR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt   <= '0;
      car_count  <= '0;
      lr_has_car <= 1'b0;
    end else begin
      if (!green || drain_tick) begin
        pass_cnt <= '0;
      end else begin
        pass_cnt <= pass_cnt + PASS_ONE;
      end
      car_count  <= count_next;
      lr_has_car <= (count_next != '0) || fault_next;
    end
  end

`ifdef LR_CAR_STUCK_DETECT_EN
  localparam int unsigned   SW         = cnt_width(STUCK_CYCLES);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);
  localparam logic [SW-1:0] STUCK_ONE  = SW'(1);

  logic [SW-1:0] stuck_cnt;

  // The fault is raised on the STUCK_CYCLES-th edge spent in PRESENT and
  // holds until the FSM is back in IDLE.
  always_comb begin
    fault_next = sensor_fault;
    if (deb_state == DEB_IDLE) begin
      fault_next = 1'b0;
    end else if ((deb_state == DEB_PRESENT) && (stuck_cnt == STUCK_LAST)) begin
      fault_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stuck_cnt    <= '0;
      sensor_fault <= 1'b0;
    end else begin
      if (deb_state != DEB_PRESENT) begin
        stuck_cnt <= '0;
      end else if (stuck_cnt != STUCK_LAST) begin
        stuck_cnt <= stuck_cnt + STUCK_ONE;
      end
      sensor_fault <= fault_next;
    end
  end
`else
  logic unused_cfg;

  assign fault_next   = 1'b0;
  assign sensor_fault = 1'b0;
  assign unused_cfg   = ^{deb_state, STUCK_CYCLES};
`endif

endmodule

// File: doc/lr_car_detector.md
# lr_car_detector

Upstream stage of the traffic light controller: conditions the raw local-road vehicle loop sensor and produces the `lr_has_car` request the controller consumes. It synchronises and debounces the sensor and counts arriving cars in a saturating queue. The queue drains while the local road shows green, and `lr_has_car` stays asserted while cars remain queued.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised samples required to accept a sensor edge; must be ≥ 2.
- `MAX_CARS`, 7: saturation value of the car queue.
- `PASS_CYCLES`, 10: local-road green cycles needed to discharge one car.
- `STUCK_CYCLES`, 200: PRESENT cycles before a sensor fault is flagged (only with the macro).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `sensor_raw`  in  1  asynchronous loop sensor, high while a car is over the loop.
- `lr_light`  in  3  local-road light from the controller: 100 green, 010 yellow, 001 red.
- `lr_has_car`  out  1  registered request to the controller.
- `car_count`  out  $clog2(MAX_CARS+1)  queued cars.
- `sensor_fault`  out  1  stuck-sensor flag.

## Operation
- Synchroniser: `sensor_raw` → `sync1` → `sync2`; the FSM samples only `sync2`.
- Debounce FSM states: IDLE, RISE_CHK, PRESENT, FALL_CHK. `deb_cnt` counts samples.
- IDLE: `sync2`=1 → RISE_CHK, `deb_cnt`=1.
- RISE_CHK:
  - `sync2`=0 → IDLE.
  - `sync2`=1 and `deb_cnt`==DEBOUNCE_CYCLES-1 → PRESENT and count one car.
  - Otherwise increment `deb_cnt`.
- PRESENT: `sync2`=0 → FALL_CHK, `deb_cnt`=1.
- FALL_CHK:
  - `sync2`=1 → PRESENT; no new car is counted.
  - `sync2`=0 and `deb_cnt`==DEBOUNCE_CYCLES-1 → IDLE.
  - Otherwise increment `deb_cnt`.
- Drain:
  - `pass_cnt` increments on each cycle with `lr_light`==100.
  - When `pass_cnt` reaches PASS_CYCLES-1 it returns to 0 and the queue decrements, if nonzero.
  - Any non-green `lr_light` clears `pass_cnt`.
  - Yellow and red never drain.
- Queue arithmetic:
  - Increment saturates at MAX_CARS; decrement floors at 0.
  - Increment and decrement on the same edge: `car_count` is unchanged (net zero).
  - At saturation, a simultaneous increment and decrement also nets zero, so the value stays MAX_CARS.
- `lr_has_car` is registered from the next-state queue: (next `car_count` != 0) OR fault forcing.
- Unused or illegal FSM encodings return to IDLE.

## Timing
- Reset values: `sync1`, `sync2`, `deb_cnt`, `pass_cnt`, stuck counter all 0; FSM in IDLE; `car_count`=0, `lr_has_car`=0, `sensor_fault`=0.
- Sensor rise latency: with `sensor_raw` high from just before edge E and held, the car is counted and `lr_has_car`=1 after edge E+1+DEBOUNCE_CYCLES (E+5 at default).
- Pulse rejection: a pulse shorter than DEBOUNCE_CYCLES sampled cycles is never counted.
- Drain latency: `lr_has_car` falls on the same edge that decrements the last car.
- Reset asserted mid-operation: every state above returns to its reset value on the next edge; a car in progress is discarded.

## Configuration
- `LR_CAR_STUCK_DETECT_EN` defined:
  - A stuck counter runs while in PRESENT; it clears on leaving PRESENT.
  - When the counter reaches STUCK_CYCLES, `sensor_fault`=1.
  - The fault is sticky until the FSM returns to IDLE or `rst`.
  - While faulted, `lr_has_car` is forced to 1 (fail-safe service for the local road).
- Not defined: no stuck counter; `sensor_fault` is tied to 0.

## Structure
- Shared package `traffic_pkg`:
  - light encodings `LIGHT_GREEN`=3'b100, `LIGHT_YELLOW`=3'b010, `LIGHT_RED`=3'b001;
  - debounce state encodings.
- One sub-module: `sensor_debounce` (synchroniser plus 4-state FSM).
  - Outputs a one-cycle `car_arrive` pulse on the RISE_CHK→PRESENT transition, plus the FSM state.
- The top level holds the queue, drain counter and stuck logic.

## Test plan
All scenarios use default parameters unless noted, with MAX_CARS=3 and STUCK_CYCLES=50.
- Reset: `rst`=1 for 2 edges with `sensor_raw`=1 → `car_count`=0, `lr_has_car`=0, `sensor_fault`=0.
- Glitches: `sensor_raw` high for 3 cycles, then low, repeated 5 times with `lr_light`=001 → `car_count` stays 0, `lr_has_car` stays 0.
- Single car: `sensor_raw` high from before edge E for 12 cycles → `lr_has_car`=1 after edge E+5, `car_count`=1.
- Saturation:
  - 5 clean cars (high 10, low 10), red light → `car_count`=3.
  - Then a 2-cycle low dropout inside a car → no extra count.
- Drain and simultaneous events:
  - `car_count`=2, `lr_light`=100 → decrement after the 10th green edge, 0 after the 20th, `lr_has_car` falls on the 20th.
  - A car arrival landing on a decrement edge → `car_count` unchanged.
- Stuck sensor (macro defined): `sensor_raw` held high with green drain running → `sensor_fault`=1 after 50 PRESENT cycles, `lr_has_car`=1 even with `car_count`=0.
  - `sensor_raw` low for 4 sampled cycles → `sensor_fault` clears.
